// File: rtl/hilo_muldiv_seq_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide sequencer.
// The master side is EX (operation, operands, flush, MF probe); the slave side is the sequencer.
interface hilo_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             mf_req;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, src_a, src_b, cancel, mf_req,
        input  busy, stall, done, div_zero, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b, cancel, mf_req,
        output busy, stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO: fixed-latency multiply, radix-2 restoring
// divide with a sign-fix cycle, and a combinational stall towards the hazard unit.
module hilo_muldiv_seq #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    hilo_muldiv_seq_if.slave  bus
);
    localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;

    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign a_neg     = signed_op & bus.src_a[WIDTH-1];
    assign b_neg     = signed_op & bus.src_b[WIDTH-1];
    // Two's-complement negation of the most negative value yields its own bit pattern,
    // which read as unsigned is exactly the magnitude.
    assign a_mag     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign b_mag     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    assign ext_a     = {{WIDTH{a_neg}}, bus.src_a};
    assign ext_b     = {{WIDTH{b_neg}}, bus.src_b};

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge    = rem_sh >= {1'b0, dvs_q};
    assign rem_sub   = rem_sh[WIDTH-1:0] - dvs_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !bus.cancel) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = ext_a * ext_b;
                            cnt_d   = CW'(MUL_CYCLES - 1);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.src_b == '0) begin
                                done_d = 1'b1;
                                dz_d   = 1'b1;
                            end else begin
                                rem_d   = '0;
                                quo_d   = a_mag;
                                dvs_d   = b_mag;
                                q_neg_d = a_neg ^ b_neg;
                                r_neg_d = a_neg;
                                cnt_d   = CW'(WIDTH - 1);
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod_q;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DIV: begin
                rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], rem_ge};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_FIX: begin
                lo_d    = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                done_d  = 1'b1;
                dz_d    = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A flush discards whatever the cycle would have committed.
        if (bus.cancel) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dz_d    = dz_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.stall    = busy_q & (bus.op_valid | bus.mf_req);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
